// File: rtl/lsu_defs.sv
// Shared definitions for the MEM-stage load/store unit.
//   - RV32I load/store funct3 width codes
//   - LSU control state encoding
package lsu_defs;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter.
//   rdata  : raw 32-bit bus word
//   funct3 : load width code (lb/lh/lw/lbu/lhu)
//   addr   : byte offset within the word
//   result : byte/halfword lane selected and sign/zero extended
module load_formatter
    import lsu_defs::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[7:0];
        case (addr)
            2'd0: w_byte = rdata[7:0];
            2'd1: w_byte = rdata[15:8];
            2'd2: w_byte = rdata[23:16];
            2'd3: w_byte = rdata[31:24];
            default: w_byte = rdata[7:0];
        endcase
    end

    assign w_half = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = rdata;
        case (funct3)
            F3_B:    result = {{24{w_byte[7]}}, w_byte};
            F3_BU:   result = {24'd0, w_byte};
            F3_H:    result = {{16{w_half[15]}}, w_half};
            F3_HU:   result = {16'd0, w_half};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit. Issues one bus access per load/store in the
// MEM stage and holds the pipeline (stall) until the access completes.
//   clk, reset        : clock, async active-low reset
//   memRead/memWrite  : load/store in MEM stage
//   funct3, aluResult : width code and effective byte address
//   writeData         : store data
//   stall             : freezes upstream pipeline registers
//   memoryRes         : formatted load data, non-zero only in DONE
//   accessFault       : misaligned/illegal access (IDLE only)
//   busError          : timeout abort flag, meaningful in DONE
//   memReq/memWe/memAddr/memWdata/memByteEn : registered bus request
//   memRdata/memReady : bus response
module lsu_mem_stage
    import lsu_defs::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] aluResult,
    input  logic [31:0] writeData,
    output logic        stall,
    output logic [31:0] memoryRes,
    output logic        accessFault,
    output logic        busError,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memByteEn,
    input  logic [31:0] memRdata,
    input  logic        memReady
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_e       r_state, w_next;
    logic [2:0]       r_funct3;
    logic [1:0]       r_addr_lo;
    logic [31:0]      r_data;
    logic [CNT_W-1:0] r_cnt;

    logic        w_access, w_fault, w_start, w_timeout;
    logic        w_is_b, w_is_h, w_is_w;
    logic [3:0]  w_byteEn;
    logic [31:0] w_wdata, w_ld_fmt;

    assign w_access = memRead | memWrite;
    assign w_is_b   = (funct3 == F3_B) || (funct3 == F3_BU);
    assign w_is_h   = (funct3 == F3_H) || (funct3 == F3_HU);
    assign w_is_w   = (funct3 == F3_W);

    // Raw fault predicate; only reported while IDLE with an access present.
    assign w_fault = !(w_is_b || w_is_h || w_is_w)
                   || (memWrite && ((funct3 == F3_BU) || (funct3 == F3_HU)))
                   || (memRead && memWrite)
                   || (w_is_h && aluResult[0])
                   || (w_is_w && (aluResult[1:0] != 2'b00));

    // TIMEOUT_CYCLES=0 disables the abort; the counter may then wrap harmlessly.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Store lane formatting; loads always enable the full word.
    always_comb begin
        w_byteEn = 4'b1111;
        w_wdata  = writeData;
        if (memWrite) begin
            case (funct3)
                F3_B: begin
                    w_byteEn = 4'b0001 << aluResult[1:0];
                    w_wdata  = {4{writeData[7:0]}};
                end
                F3_H: begin
                    w_byteEn = aluResult[1] ? 4'b1100 : 4'b0011;
                    w_wdata  = {2{writeData[15:0]}};
                end
                default: begin
                    w_byteEn = 4'b1111;
                    w_wdata  = writeData;
                end
            endcase
        end
    end

    load_formatter u_fmt (
        .rdata  (memRdata),
        .funct3 (r_funct3),
        .addr   (r_addr_lo),
        .result (w_ld_fmt)
    );

    always_comb begin
        w_next      = r_state;
        stall       = 1'b0;
        memoryRes   = 32'd0;
        accessFault = 1'b0;
        case (r_state)
            IDLE: begin
                accessFault = w_access & w_fault;
                if (w_access && !w_fault) begin
                    stall  = 1'b1;
                    w_next = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (memReady || w_timeout)
                    w_next = DONE;
            end
            DONE: begin
                // Pipeline advances on this edge; never re-sample the inputs here.
                memoryRes = r_data;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_start = (r_state == IDLE) && (w_next == REQ);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            memReq    <= 1'b0;
            memWe     <= 1'b0;
            memAddr   <= 32'd0;
            memWdata  <= 32'd0;
            memByteEn <= 4'd0;
            r_funct3  <= 3'd0;
            r_addr_lo <= 2'd0;
            r_data    <= 32'd0;
            r_cnt     <= '0;
            busError  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        memReq    <= 1'b1;
                        memWe     <= memWrite;
                        memAddr   <= {aluResult[31:2], 2'b00};
                        memByteEn <= w_byteEn;
                        memWdata  <= w_wdata;
                        r_funct3  <= funct3;
                        r_addr_lo <= aluResult[1:0];
                        r_cnt     <= '0;
                    end
                end
                REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (memReady) begin
                        memReq <= 1'b0;
                        r_data <= memWe ? 32'd0 : w_ld_fmt;
                    end else if (w_timeout) begin
                        memReq   <= 1'b0;
                        r_data   <= 32'd0;
                        busError <= 1'b1;
                    end
                end
                DONE: begin
                    r_cnt    <= '0;
                    busError <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        memRead, memWrite;
    logic [2:0]  funct3;
    logic [31:0] aluResult, writeData;
    logic        stall, accessFault, busError;
    logic [31:0] memoryRes;
    logic        memReq, memWe;
    logic [31:0] memAddr, memWdata;
    logic [3:0]  memByteEn;
    logic [31:0] memRdata;
    logic        memReady;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .funct3     (funct3),
        .aluResult  (aluResult),
        .writeData  (writeData),
        .stall      (stall),
        .memoryRes  (memoryRes),
        .accessFault(accessFault),
        .busError   (busError),
        .memReq     (memReq),
        .memWe      (memWe),
        .memAddr    (memAddr),
        .memWdata   (memWdata),
        .memByteEn  (memByteEn),
        .memRdata   (memRdata),
        .memReady   (memReady)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Load with memReady in the first REQ cycle. Called just after a negedge.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rd, input logic [31:0] exp);
        memRead = 1'b1; funct3 = f3; aluResult = addr;
        #1;
        chk({tag, "_idle_stall"}, 32'(stall), 32'd1);
        chk({tag, "_idle_fault"}, 32'(accessFault), 32'd0);
        @(posedge clk); @(negedge clk);
        chk({tag, "_req"}, 32'(memReq), 32'd1);
        chk({tag, "_addr"}, memAddr, {addr[31:2], 2'b00});
        chk({tag, "_be"}, 32'(memByteEn), 32'hF);
        chk({tag, "_we"}, 32'(memWe), 32'd0);
        chk({tag, "_req_res"}, memoryRes, 32'd0);
        memReady = 1'b1; memRdata = rd;
        @(posedge clk); @(negedge clk);
        memReady = 1'b0; memRdata = 32'd0;
        chk({tag, "_done_stall"}, 32'(stall), 32'd0);
        chk({tag, "_done_req"}, 32'(memReq), 32'd0);
        chk({tag, "_done_res"}, memoryRes, exp);
        memRead = 1'b0;
        @(posedge clk); @(negedge clk);
        chk({tag, "_idle_res"}, memoryRes, 32'd0);
    endtask

    // Store with memReady in REQ cycle nreq. Called just after a negedge.
    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input int nreq, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd, input logic [31:0] exp_addr);
        memWrite = 1'b1; funct3 = f3; aluResult = addr; writeData = wd;
        #1;
        chk({tag, "_idle_stall"}, 32'(stall), 32'd1);
        @(posedge clk);
        for (int i = 0; i < nreq; i++) begin
            @(negedge clk);
            chk({tag, "_req"}, 32'(memReq), 32'd1);
            chk({tag, "_we"}, 32'(memWe), 32'd1);
            chk({tag, "_addr"}, memAddr, exp_addr);
            chk({tag, "_be"}, 32'(memByteEn), 32'(exp_be));
            chk({tag, "_wdata"}, memWdata, exp_wd);
            chk({tag, "_stall"}, 32'(stall), 32'd1);
            if (i == nreq - 1) memReady = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        memReady = 1'b0;
        chk({tag, "_done_stall"}, 32'(stall), 32'd0);
        chk({tag, "_done_res"}, memoryRes, 32'd0);
        chk({tag, "_done_req"}, 32'(memReq), 32'd0);
        memWrite = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; memRead = 1'b0; memWrite = 1'b0; funct3 = 3'd0;
        aluResult = 32'd0; writeData = 32'd0; memRdata = 32'd0; memReady = 1'b0;
        #12;
        chk("rst_req", 32'(memReq), 32'd0);
        chk("rst_we", 32'(memWe), 32'd0);
        chk("rst_addr", memAddr, 32'd0);
        chk("rst_wdata", memWdata, 32'd0);
        chk("rst_be", 32'(memByteEn), 32'd0);
        chk("rst_buserr", 32'(busError), 32'd0);
        chk("rst_res", memoryRes, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);

        // Loads
        do_load("lw100", 3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
        do_load("lb203", 3'b000, 32'h203, 32'h80FFFFFF, 32'hFFFFFF80);
        do_load("lbu203", 3'b100, 32'h203, 32'h80FFFFFF, 32'h00000080);
        do_load("lhu202", 3'b101, 32'h202, 32'h80010000, 32'h00008001);
        do_load("lh202", 3'b001, 32'h202, 32'h80010000, 32'hFFFF8001);
        do_load("lb001", 3'b000, 32'h001, 32'h00007F00, 32'h0000007F);

        // Stores
        do_store("sh306", 3'b001, 32'h306, 32'h1234ABCD, 3, 4'b1100, 32'hABCDABCD, 32'h304);
        do_store("sb101", 3'b000, 32'h101, 32'h000000A5, 1, 4'b0010, 32'hA5A5A5A5, 32'h100);
        do_store("sw208", 3'b010, 32'h208, 32'hCAFEF00D, 2, 4'b1111, 32'hCAFEF00D, 32'h208);

        // Faults: never reach the bus
        memRead = 1'b1; funct3 = 3'b010; aluResult = 32'h102;
        #1;
        chk("flt_lw_mis", 32'(accessFault), 32'd1);
        chk("flt_lw_stall", 32'(stall), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("flt_lw_req", 32'(memReq), 32'd0);
        chk("flt_lw_stall2", 32'(stall), 32'd0);
        funct3 = 3'b011; aluResult = 32'h100;
        #1;
        chk("flt_f3_011", 32'(accessFault), 32'd1);
        memRead = 1'b0; memWrite = 1'b1; funct3 = 3'b100;
        #1;
        chk("flt_sbu", 32'(accessFault), 32'd1);
        memWrite = 1'b0;
        #1;
        chk("flt_noacc", 32'(accessFault), 32'd0);
        @(negedge clk);

        // Timeout: memReq high exactly 4 cycles
        memRead = 1'b1; funct3 = 3'b010; aluResult = 32'h400;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_req", 32'(memReq), 32'd1);
            chk("to_stall", 32'(stall), 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        chk("to_done_req", 32'(memReq), 32'd0);
        chk("to_done_buserr", 32'(busError), 32'd1);
        chk("to_done_res", memoryRes, 32'd0);
        chk("to_done_stall", 32'(stall), 32'd0);
        memRead = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("to_idle_buserr", 32'(busError), 32'd0);
        chk("to_idle_stall", 32'(stall), 32'd0);

        // Reset mid-access
        memRead = 1'b1; funct3 = 3'b010; aluResult = 32'h500;
        @(posedge clk); @(negedge clk);
        chk("rr_req", 32'(memReq), 32'd1);
        #2;
        reset = 1'b0; memRead = 1'b0;
        #1;
        chk("rr_req_async", 32'(memReq), 32'd0);
        chk("rr_stall_async", 32'(stall), 32'd0);
        chk("rr_addr_async", memAddr, 32'd0);
        @(negedge clk);
        reset = 1'b1; memReady = 1'b1; memRdata = 32'h0000FFFF;
        @(posedge clk); @(negedge clk);
        chk("rr_idle_ready_req", 32'(memReq), 32'd0);
        chk("rr_idle_ready_stall", 32'(stall), 32'd0);
        chk("rr_idle_ready_res", memoryRes, 32'd0);
        memReady = 1'b0; memRdata = 32'd0;
        do_load("rr_lw600", 3'b010, 32'h600, 32'h12345678, 32'h12345678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- MEM-stage load/store unit of the 5-stage RISC-V pipeline.
- Sits between the EX/MEM pipeline register and the data-memory bus. Its memoryRes output feeds the MEM/WB register's memory-result input.
- Runs a request/ready handshake on the bus, formats sub-word loads and stores, and raises stall to freeze the upstream pipeline registers until the access completes.
- Flags misaligned or illegal accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: maximum REQ-state cycles without memReady before the access is aborted; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- memRead  in  1  load in MEM stage
- memWrite  in  1  store in MEM stage
- funct3  in  3  RV32I load/store width code
- aluResult  in  32  effective byte address
- writeData  in  32  store data (rs2)
- stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB write enables
- memoryRes  out  32  formatted load data for the MEM/WB register
- accessFault  out  1  misaligned address or illegal funct3 on the current access
- busError  out  1  timeout abort, valid in DONE
- memReq  out  1  bus request, registered
- memWe  out  1  bus write, registered
- memAddr  out  32  word address {aluResult[31:2],2'b00}, registered
- memWdata  out  32  lane-replicated store data, registered
- memByteEn  out  4  byte enables, registered
- memRdata  in  32  bus read data, valid when memReady=1
- memReady  in  1  bus completion strobe

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; memReq=0, memWe=0, memAddr=0, memWdata=0, memByteEn=0; captured-data register=0; timeout counter=0; busError=0. Combinational outputs follow from IDLE with the current inputs.
- Access condition: access = memRead|memWrite.
- accessFault (combinational, IDLE only) is set when access=1 and any of:
  - funct3 is not in {000,001,010,100,101};
  - funct3 is 100 or 101 with memWrite=1;
  - memRead=1 and memWrite=1;
  - halfword access with aluResult[0]=1;
  - word access with aluResult[1:0]!=0.
- IDLE:
  - access=0 or accessFault=1: stall=0, memoryRes=0, no bus activity.
  - access=1 and no fault: stall=1, go to REQ. Latch memAddr, memWe=memWrite, memByteEn, memWdata, and latch funct3 and aluResult[1:0] internally. memReq=1 from the next cycle.
- REQ:
  - memReq=1 held and bus outputs stable; stall=1; counter increments each cycle.
  - memReady=1: capture the formatted load (0 for stores) into the data register, memReq=0, go to DONE.
  - TIMEOUT_CYCLES>0 and counter reaches TIMEOUT_CYCLES-1 without memReady: memReq=0, data register=0, busError=1, go to DONE.
- DONE:
  - stall=0; memoryRes=data register; the pipeline advances on this edge.
  - Next state is always IDLE. The inputs are not re-sampled, so the same instruction is never reissued.
  - Counter and busError clear on leaving DONE.
- memoryRes=0 in every state except DONE.
- Minimum latency: memReady in the first REQ cycle gives 2 stall cycles; the instruction leaves MEM on the 3rd cycle.
- memReady outside REQ is ignored.
- Store formatting:
  - sb: byteEn=0001<<addr[1:0], wdata={4{wd[7:0]}}.
  - sh: byteEn=0011 (addr[1]=0) or 1100 (addr[1]=1), wdata={2{wd[15:0]}}.
  - sw: byteEn=1111, wdata=wd.
- Load formatting (byte lane = addr[1:0], half lane = addr[1]):
  - lb: sign-extend the selected byte. lbu: zero-extend it.
  - lh: sign-extend the selected halfword. lhu: zero-extend it.
  - lw: rdata unchanged.
  - For loads, memByteEn=1111.
- Reset mid-access: immediate return to IDLE, memReq drops asynchronously, the access is abandoned.

Decomposition:
- Shared package/include lsu_defs:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - state encoding IDLE/REQ/DONE.
- Sub-module load_formatter (combinational): inputs rdata, funct3, addr[1:0]; output the 32-bit extended value.

Test Plan:
- lw at 0x100, memReady in first REQ cycle with rdata=0xDEADBEEF -> stall high 2 cycles; memReq=1 for 1 cycle with memAddr=0x100, memByteEn=1111; memoryRes=0xDEADBEEF in DONE.
- lb at 0x203 with rdata=0x80FFFFFF -> memoryRes=0xFFFFFF80. lbu at the same address -> 0x00000080. lhu at 0x202 with rdata=0x8001_0000 -> 0x00008001.
- sh at 0x306 with writeData=0x1234ABCD, memReady after 3 REQ cycles -> memWe=1, memAddr=0x304, memByteEn=1100, memWdata=0xABCDABCD; stall for 4 cycles; memoryRes=0 in DONE.
- lw at 0x102 -> accessFault=1, stall=0, memReq never asserted. funct3=011 with memRead -> accessFault=1.
- TIMEOUT_CYCLES=4, lw with memReady held low -> memReq high exactly 4 cycles, then DONE with busError=1, memoryRes=0, stall=0; IDLE next cycle.
- reset driven to 0 during REQ -> memReq=0 and stall=0 without a clock edge. After release, a new lw completes normally; memReady arriving in IDLE has no effect.
